ram_block_reader: RTL and testbench

- Avalon-MM read master that drains a contiguous block of 32-bit words from the 1024x32 on-chip RAM slave (single-port, fixed 1-cycle read latency, no waitrequest) and presents them as an Avalon-ST stream with valid/ready backpressure.
- Sits between the HPS-loaded sample/coefficient RAM and the FIR datapath.
- The host/sequencer supplies base address and word count, then pulses start.

---
 rtl/ram_reader_pkg.sv | 22 ++
 rtl/ram_reader_fifo.sv | 69 ++++++
 rtl/ram_block_reader.sv | 132 +++++++++++++
 tb/tb_ram_block_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// rtl/ram_reader_pkg.sv - shared widths, FSM state type and RAM timing for the block reader
//
// Purpose : common definitions imported by ram_block_reader and ram_reader_fifo.
// Contents: default widths, RAM read latency, reader FSM state enum.
package ram_reader_pkg;

    localparam int ADDR_W_DEF       = 10;
    localparam int DATA_W_DEF       = 32;
    localparam int LEN_W_DEF        = 11;
    localparam int FIFO_DEPTH_DEF   = 4;

    // The on-chip RAM returns data exactly one cycle after the request,
    // which is why a single in-flight flag is enough to track outstanding reads.
    localparam int RAM_READ_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_reader_fifo.sv
// rtl/ram_reader_fifo.sv - output skid FIFO with fall-through of the incoming word
//
// Purpose : DEPTH-entry synchronous FIFO between RAM read data and the stream.
//           When empty, the word being pushed is visible on head in the same
//           cycle, so the stream sees RAM data without an extra register stage.
// Ports   : clk, reset       - clock, synchronous active-high reset (flushes)
//           push, push_data  - write strobe and data
//           pop              - consume head (only when head_valid)
//           head, head_valid - current head word and its valid
//           count            - number of stored entries (bypassed word excluded)
module ram_reader_fifo
    import ram_reader_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              bypass;
    logic              wr_en;
    logic              rd_en;

    assign empty  = (count == '0);
    // Word arrives and leaves in the same cycle while empty: never stored.
    assign bypass = empty & push & pop;
    assign wr_en  = push & ~bypass;
    assign rd_en  = pop & ~empty;

    assign head       = empty ? push_data : mem[rd_ptr];
    assign head_valid = ~empty | push;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/ram_block_reader.sv
// rtl/ram_block_reader.sv - Avalon-MM block read master feeding an Avalon-ST stream
//
// Purpose : reads `length` consecutive words starting at `base_addr` from the
//           1-cycle-latency on-chip RAM and streams them out in address order.
// Ports   : clk, reset                      - clock, synchronous active-high reset
//           start, base_addr, length        - command (accepted only when idle)
//           busy, done                      - status (done is a one-cycle pulse)
//           m_address, m_chipselect,
//           m_write, m_byteenable, m_clken,
//           m_readdata                      - RAM master port
//           st_data, st_valid, st_ready     - output stream
module ram_block_reader
    import ram_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining;
    logic              inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;

    assign pop = st_valid & st_ready;

    // Words that will be held after this cycle: stored + arriving - leaving.
    // A new request lands next cycle, so it needs occupancy < FIFO_DEPTH.
    assign occupancy = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

    assign issue = (state == READ) && (remaining != '0)
                && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign m_chipselect = issue;
    assign m_address    = addr_q;

    // Read data returns one cycle after the request: push it then.
    ram_reader_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight),
        .push_data  (m_readdata),
        .pop        (pop),
        .head       (st_data),
        .head_valid (st_valid),
        .count      (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remaining <= length;
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q    <= addr_q + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Finish on the cycle the last word leaves, so done lands
                    // one cycle after the final stream accept.
                    if (occupancy == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_reader.sv
// tb/tb_ram_block_reader.sv - self-checking bench for ram_block_reader
module tb_ram_block_reader;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 11;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_WORDS  = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;

    always #5 clk = ~clk;

    ram_block_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .st_data      (st_data),
        .st_valid     (st_valid),
        .st_ready     (st_ready)
    );

    // RAM slave model: registered read, one cycle latency.
    logic [DATA_W-1:0] mem [RAM_WORDS];
    always @(posedge clk) begin
        if (m_chipselect) m_readdata <= mem[m_address];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation state, gathered at the falling edge.
    logic [DATA_W-1:0] got_q [$];
    int                addr_q [$];
    int                n_issued, n_popped, done_cnt, done_cyc;
    int                first_pop_cyc, last_pop_cyc, busy_cycles;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        n_issued = 0; n_popped = 0; done_cnt = 0; done_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1; busy_cycles = 0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", st_valid, 1);
                check_eq("stall_data", st_data, prev_data);
            end
            if (m_chipselect) begin
                addr_q.push_back(int'(m_address));
                // Words outstanding after this cycle must fit in the FIFO.
                check_eq("credit", (n_issued + 1 - n_popped - int'(st_valid && st_ready)) <= FIFO_DEPTH, 1);
                n_issued++;
            end
            if (st_valid && st_ready) begin
                got_q.push_back(st_data);
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                n_popped++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cycles++;
            prev_stall = st_valid && !st_ready;
            prev_data  = st_data;
        end
    end

    function automatic logic ready_for(input int mode, input int j);
        case (mode)
            0:       return 1'b1;
            1:       return (j % 4) == 0;
            default: return $urandom_range(0, 99) < 60;
        endcase
    endfunction

    task automatic do_xfer(input int base, input int len, input int mode, input bit inject);
        int t0, j, budget, idx;
        clear_mon();
        budget = len * 8 + 20;
        @(posedge clk); #1;
        base_addr = ADDR_W'(base);
        length    = LEN_W'(len);
        start     = 1'b1;
        st_ready  = ready_for(mode, 0);
        t0 = cyc;
        @(negedge clk); #1;
        j = 0;
        while (done_cnt == 0 && j < budget) begin
            @(posedge clk); #1;
            j++;
            start = inject && (j == 3);
            if (inject) begin
                base_addr = ADDR_W'(base + 100);
                length    = LEN_W'(5);
            end
            st_ready = ready_for(mode, j);
            @(negedge clk); #1;
        end
        start = 1'b0;
        check_eq("done_seen", done_cnt > 0, 1);
        if (len == 0) begin
            check_eq("zero_done_cyc", done_cyc, t0 + 1);
            check_eq("zero_no_req", n_issued, 0);
            check_eq("zero_busy", busy_cycles, 0);
        end else begin
            check_eq("word_count", got_q.size(), len);
            for (int i = 0; i < len; i++) begin
                idx = (base + i) % RAM_WORDS;
                if (i < got_q.size()) check_eq("data", got_q[i], mem[idx]);
                if (i < addr_q.size()) check_eq("addr", addr_q[i], idx);
            end
            check_eq("done_after_last", done_cyc, last_pop_cyc + 1);
            check_eq("busy_span", busy_cycles, done_cyc - t0 - 1);
            if (mode == 0) begin
                check_eq("first_pop_cyc", first_pop_cyc, t0 + 2);
                check_eq("last_pop_cyc", last_pop_cyc, t0 + len + 1);
            end
        end
        st_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_eq("single_done", done_cnt, 1);
        check_eq("req_total", n_issued, len);
        check_eq("busy_idle", busy, 0);
    endtask

    initial begin
        int j;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        st_ready  = 1'b0;
        for (int i = 0; i < RAM_WORDS; i++) mem[i] = 32'(i * 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cs", m_chipselect, 0);
        check_eq("rst_addr", m_address, 0);
        check_eq("rst_valid", st_valid, 0);
        check_eq("tie_write", m_write, 0);
        check_eq("tie_be", m_byteenable, 4'hF);
        check_eq("tie_clken", m_clken, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        do_xfer(32'h010, 8, 0, 1'b0);   // basic run
        do_xfer(32'h3FE, 4, 0, 1'b0);   // address wrap
        do_xfer(32'h020, 16, 1, 1'b0);  // 1 on / 3 off backpressure
        do_xfer(32'h050, 0, 0, 1'b0);   // zero length
        do_xfer(32'h060, 6, 0, 1'b1);   // start while busy is ignored

        // Reset in the middle of a backpressured transfer.
        clear_mon();
        @(posedge clk); #1;
        base_addr = ADDR_W'(32'h100);
        length    = LEN_W'(10);
        start     = 1'b1;
        st_ready  = 1'b1;
        j = 0;
        while (got_q.size() < 3 && j < 100) begin
            @(posedge clk); #1;
            j++;
            start    = 1'b0;
            st_ready = ready_for(1, j);
            @(negedge clk); #1;
        end
        check_eq("rst_mid_reached", got_q.size(), 3);
        @(posedge clk); #1;
        reset    = 1'b1;
        st_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_valid", st_valid, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", done, 0);
        #1;
        clear_mon();
        st_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check_eq("rst_mid_no_done", done_cnt, 0);
        check_eq("rst_mid_no_req", n_issued, 0);
        check_eq("rst_mid_no_data", got_q.size(), 0);
        do_xfer(32'h200, 2, 0, 1'b0);

        // Randomised transfers over random RAM contents.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < RAM_WORDS; i++) mem[i] = $urandom;
            do_xfer(int'($urandom_range(0, RAM_WORDS - 1)), int'($urandom_range(1, 40)), 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
